// File: rtl/tlc_trace_pkg.sv
// Shared types and constants for the traffic-light trace recorder.
// Covers the frame marker, the per-entry byte count, the framer states and the entry layout.
package tlc_trace_pkg;

    localparam logic [7:0] MARKER      = 8'hC5;
    localparam int         ENTRY_BYTES = 5;
    localparam int         ENTRY_W     = 33;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_MARK,
        S_HDR_CNT,
        S_ENTRY,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [15:0] in_status;
        logic        btn;
        logic [15:0] out_status;
    } entry_t;

endpackage

// File: rtl/tlc_vec_fifo.sv
// Synchronous FIFO holding captured test vectors, DEPTH x 33 bits.
// The head entry is read combinationally so the framer can slice bytes out of it.
module tlc_vec_fifo
    import tlc_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tlc_trace_recorder.sv
// Captures traffic-light test vectors and replays them as framed byte records
// on a valid/ready stream: 0xC5, entry count, then 5 bytes per entry.
module tlc_trace_recorder
    import tlc_trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int STATUS_W = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cap_valid,
    output logic                cap_ready,
    input  logic [STATUS_W-1:0] cap_in_status,
    input  logic                cap_btn,
    input  logic [STATUS_W-1:0] cap_out_status,
    input  logic                flush,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                frame_done,
    output logic                overflow
);

    state_e      state_q, state_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  ent_cnt_q, ent_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        pend_q, pend_d;
    logic        ovf_q, ovf_d;

    logic                fifo_full, fifo_empty, pop;
    logic [CW-1:0]       fifo_count;
    logic [ENTRY_W-1:0]  fifo_dout;
    entry_t              head;

    assign cap_ready = !fifo_full;
    assign overflow  = ovf_q;
    assign head      = entry_t'(fifo_dout);

    tlc_vec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_valid && !fifo_full),
        .din   ({cap_in_status, cap_btn, cap_out_status}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        ent_cnt_d   = ent_cnt_q;
        frame_cnt_d = frame_cnt_q;
        // A flush seen while a frame is in flight is remembered for the next one.
        pend_d      = pend_q | (flush && state_q != S_IDLE);
        ovf_d       = ovf_q | (cap_valid && fifo_full);
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        frame_done  = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifo_full || ((flush || pend_q) && !fifo_empty)) begin
                    state_d     = S_HDR_MARK;
                    frame_cnt_d = 8'(fifo_count);
                    pend_d      = 1'b0;
                end
            end
            S_HDR_MARK: begin
                tx_valid = 1'b1;
                tx_data  = MARKER;
                if (tx_ready) state_d = S_HDR_CNT;
            end
            S_HDR_CNT: begin
                tx_valid = 1'b1;
                tx_data  = frame_cnt_q;
                if (tx_ready) begin
                    state_d    = S_ENTRY;
                    byte_idx_d = '0;
                    ent_cnt_d  = '0;
                end
            end
            S_ENTRY: begin
                tx_valid = 1'b1;
                case (byte_idx_q)
                    3'd0:    tx_data = head.in_status[15:8];
                    3'd1:    tx_data = head.in_status[7:0];
                    3'd2:    tx_data = {7'b0, head.btn};
                    3'd3:    tx_data = head.out_status[15:8];
                    default: tx_data = head.out_status[7:0];
                endcase
                if (tx_ready) begin
                    if (byte_idx_q == 3'(ENTRY_BYTES - 1)) begin
                        pop        = 1'b1;
                        byte_idx_d = '0;
                        ent_cnt_d  = ent_cnt_q + 8'd1;
                        if (ent_cnt_q + 8'd1 == frame_cnt_q) state_d = S_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= '0;
            ent_cnt_q   <= '0;
            frame_cnt_q <= '0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            ent_cnt_q   <= ent_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_tlc_trace_recorder.sv
// Directed bench for tlc_trace_recorder: framing, stalls, overflow, flush and reset cases.
module tb_tlc_trace_recorder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap_valid = 1'b0;
    logic        cap_btn = 1'b0;
    logic        flush = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] cap_in_status = '0;
    logic [15:0] cap_out_status = '0;
    logic        cap_ready, tx_valid, frame_done, overflow;
    logic [7:0]  tx_data;

    int total = 0;
    int passed = 0;
    logic [7:0] got[$];
    logic [7:0] expb[$];
    logic [15:0] ia [2];
    logic        ib [2];
    logic [15:0] io [2];

    always #5 clk = ~clk;

    tlc_trace_recorder #(.DEPTH(DEPTH), .STATUS_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cap_valid      (cap_valid),
        .cap_ready      (cap_ready),
        .cap_in_status  (cap_in_status),
        .cap_btn        (cap_btn),
        .cap_out_status (cap_out_status),
        .flush          (flush),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .frame_done     (frame_done),
        .overflow       (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cap(input logic [15:0] a, input logic b, input logic [15:0] o);
        @(negedge clk);
        cap_valid = 1'b1; cap_in_status = a; cap_btn = b; cap_out_status = o; flush = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        cap_valid = 1'b0; flush = 1'b1;
    endtask

    task automatic exp_hdr(input int n);
        expb.delete();
        expb.push_back(8'hC5);
        expb.push_back(8'(n));
    endtask

    task automatic exp_ent(input logic [15:0] a, input logic b, input logic [15:0] o);
        expb.push_back(a[15:8]);
        expb.push_back(a[7:0]);
        expb.push_back({7'b0, b});
        expb.push_back(o[15:8]);
        expb.push_back(o[7:0]);
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_len"}, got.size(), expb.size());
        for (int i = 0; i < got.size() && i < expb.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), got[i], expb[i]);
    endtask

    // Drains one frame, recording accepted bytes; optionally injects two
    // captures and a flush at cycle inj so they land mid-frame.
    task automatic run_frame(input bit rnd, input int inj, output int lat0, output int tdone);
        bit         stalled = 1'b0;
        bit         seen = 1'b0;
        logic [7:0] hold = '0;
        lat0 = -1; tdone = -1; got.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (stalled) chk("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold});
            cap_valid = 1'b0; flush = 1'b0;
            if (inj >= 0 && cyc == inj) begin
                cap_valid = 1'b1; cap_in_status = ia[0]; cap_btn = ib[0]; cap_out_status = io[0];
            end else if (inj >= 0 && cyc == inj + 1) begin
                cap_valid = 1'b1; cap_in_status = ia[1]; cap_btn = ib[1]; cap_out_status = io[1];
            end else if (inj >= 0 && cyc == inj + 2) begin
                flush = 1'b1;
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (frame_done) begin
                chk("done_txv", tx_valid, 0);
                tdone = cyc; seen = 1'b1;
                break;
            end
            if (tx_valid && lat0 < 0) lat0 = cyc;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            stalled = tx_valid && !tx_ready;
            hold = tx_data;
        end
        chk("frame_done_seen", seen, 1);
    endtask

    initial begin
        int         lat, td;
        bit         any;
        logic [15:0] a;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cap_ready", cap_ready, 1);
        rst_n = 1'b1;

        // Flush on an empty buffer produces nothing
        do_flush();
        any = 1'b0;
        repeat (6) begin
            @(negedge clk); flush = 1'b0;
            any |= tx_valid;
        end
        chk("empty_flush_quiet", any, 0);

        // Three captures then flush, full-rate drain
        cap(16'h1234, 1'b1, 16'hABCD);
        cap(16'h0000, 1'b0, 16'hFFFF);
        cap(16'h8001, 1'b1, 16'h0100);
        do_flush();
        exp_hdr(3);
        exp_ent(16'h1234, 1'b1, 16'hABCD);
        exp_ent(16'h0000, 1'b0, 16'hFFFF);
        exp_ent(16'h8001, 1'b1, 16'h0100);
        run_frame(1'b0, -1, lat, td);
        cmp_frame("t1");
        chk("t1_first_byte_lat", lat, 0);
        chk("t1_done_after_first", td - lat, 17);
        @(negedge clk);
        chk("t1_done_once", frame_done, 0);
        chk("t1_overflow", overflow, 0);

        // Flush during a frame chains a second frame with the later captures
        ia[0] = 16'h5A5A; ib[0] = 1'b1; io[0] = 16'h0F0F;
        ia[1] = 16'h7E57; ib[1] = 1'b0; io[1] = 16'hC0DE;
        cap(16'hAAAA, 1'b0, 16'h5555);
        cap(16'h1111, 1'b1, 16'h2222);
        do_flush();
        exp_hdr(2);
        exp_ent(16'hAAAA, 1'b0, 16'h5555);
        exp_ent(16'h1111, 1'b1, 16'h2222);
        run_frame(1'b0, 3, lat, td);
        cmp_frame("f1");
        exp_hdr(2);
        exp_ent(ia[0], ib[0], io[0]);
        exp_ent(ia[1], ib[1], io[1]);
        run_frame(1'b0, -1, lat, td);
        cmp_frame("f2");
        chk("f2_start_lat", lat, 1);

        // Fill to full with the output stalled, then two dropped captures
        tx_ready = 1'b0;
        exp_hdr(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            a = 16'(i * 4369 + 7);
            cap(a, 1'(i), ~a);
            exp_ent(a, 1'(i), ~a);
        end
        cap(16'hDEAD, 1'b1, 16'hBEEF);
        cap(16'hFACE, 1'b0, 16'hCAFE);
        @(negedge clk);
        cap_valid = 1'b0;
        chk("full_overflow", overflow, 1);
        chk("full_cap_ready", cap_ready, 0);
        chk("full_autostart_valid", tx_valid, 1);
        chk("full_autostart_marker", tx_data, 8'hC5);
        run_frame(1'b1, -1, lat, td);
        cmp_frame("full");
        @(negedge clk);
        chk("full_drained_ready", cap_ready, 1);
        chk("overflow_sticky", overflow, 1);

        // Reset in the middle of a frame
        cap(16'h2468, 1'b1, 16'h1357);
        cap(16'h9999, 1'b0, 16'h8888);
        do_flush();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); flush = 1'b0; tx_ready = 1'b1;
        end
        @(negedge clk);
        chk("pre_rst_valid", tx_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_data", tx_data, 8'h00);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_cap_ready", cap_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cap(16'h0102, 1'b1, 16'h0304);
        cap(16'hFFFF, 1'b0, 16'h0000);
        do_flush();
        exp_hdr(2);
        exp_ent(16'h0102, 1'b1, 16'h0304);
        exp_ent(16'hFFFF, 1'b0, 16'h0000);
        run_frame(1'b0, -1, lat, td);
        cmp_frame("post_rst");
        chk("post_rst_lat", lat, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tlc_trace_recorder.md
# tlc_trace_recorder

Hardware counterpart of the traffic-light test-vector player. It captures per-step vectors (applied light status, button, resulting light status) from the traffic-light controller's test harness into a buffer. It then serialises them as framed byte records, one count header followed by the entries, on a valid/ready byte stream feeding the board UART transmitter. An off-chip tool writes these records back out as decoded test-case files, closing the loop with the vector reader.

## Interface
Parameters:
- DEPTH, 16, entries buffered per frame; power of two, 2..128
- STATUS_W, 16, width of light-status words; fixed at 16 for this frame format

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cap_valid  in  1  capture request for the current step
- cap_ready  out  1  buffer can accept an entry (= not full)
- cap_in_status  in  16  light status applied to the controller
- cap_btn  in  1  button value applied
- cap_out_status  in  16  light status reported by the controller
- flush  in  1  single-cycle pulse: close the current frame early
- tx_data  out  8  serial byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts the byte
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted
- overflow  out  1  sticky: a capture was dropped

## Operation
- Entry = {in_status, btn, out_status} (33 bits), pushed into the FIFO when cap_valid && cap_ready.
- If cap_valid && !cap_ready: entry dropped, overflow set; only reset clears it.
- FSM states: IDLE, HDR_MARK, HDR_CNT, ENTRY, DONE.
- IDLE -> HDR_MARK when the FIFO is full, or when (flush or pending_flush) and occupancy > 0. On entry, frame_cnt latches the occupancy.
- flush with occupancy 0 in IDLE: ignored.
- flush outside IDLE: sets pending_flush. pending_flush is cleared when the next frame starts.
- HDR_MARK sends 0xC5, then HDR_CNT sends frame_cnt (DEPTH encodes as its 8-bit value).
- ENTRY sends 5 bytes per entry, MSB first: in_status[15:8], in_status[7:0], {7'b0,btn}, out_status[15:8], out_status[7:0].
  - The FIFO pops on acceptance of byte 4.
  - After frame_cnt entries -> DONE.
- DONE: frame_done = 1 for one cycle -> IDLE.
- Capture continues during a frame. Entries pushed after frame start belong to the next frame, because frame_cnt is fixed at start.
- Simultaneous push and pop in the same cycle: both take effect; occupancy unchanged.

## Timing
- Reset values: tx_valid 0, tx_data 0x00, frame_done 0, overflow 0, cap_ready 1. FIFO is empty, FSM is in IDLE, pending_flush is 0.
- Trigger seen in cycle N: tx_valid = 1 with 0xC5 in cycle N+1.
- A byte transfers on a rising edge with tx_valid && tx_ready. The next byte is valid in the following cycle, with no bubble. With tx_ready held at 1, a frame takes 2 + 5·frame_cnt cycles.
- While tx_valid && !tx_ready, tx_data is held stable. tx_valid never drops before acceptance.
- frame_done is asserted the cycle after the last byte is accepted. tx_valid is 0 in that cycle.
- cap_ready is registered and reflects occupancy after the previous edge. A pop in the same cycle does not make room for a push.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is abandoned and buffered entries are lost.

## Structure
- Package tlc_trace_pkg holds:
  - the MARKER = 8'hC5 and ENTRY_BYTES = 5 constants
  - the FSM state enum
  - the 33-bit entry typedef
- Sub-module tlc_vec_fifo: synchronous FIFO, DEPTH × 33. Ports: push/pop/full/empty/count; count is $clog2(DEPTH)+1 bits wide.
- Top-level: framing FSM, byte index counter (0..4), entry counter, flush latch.

## Test plan
- Capture 3 entries ({0x1234,1,0xABCD}, {0x0000,0,0xFFFF}, {0x8001,1,0x0100}), then flush, tx_ready = 1.
  - Required bytes: C5 03 12 34 01 AB CD 00 00 00 FF FF 80 01 01 01 00.
  - frame_done pulses once, 17 cycles after the first byte.
- Capture DEPTH = 16 entries with no flush: frame auto-starts; count byte 0x10, 82 bytes total.
- tx_ready toggled pseudo-randomly during a frame: the byte sequence is identical to the tx_ready = 1 case, and tx_data is stable while stalled.
- Fill to full, then cap_valid for 2 more cycles while draining is stalled: overflow = 1, dropped entries never appear.
- Flush with an empty FIFO gives no output. Flush during a frame gives a second frame immediately after frame_done, carrying only the entries captured after the first frame started.
- rst_n low after 7 bytes of a frame: tx_valid drops immediately. After release, 2 new captures + flush give a clean frame starting C5 02.
